// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite word SRAM slave with programmable wait states and two-cycle ERROR.
// Optional SEQ burst address checking is enabled by defining AHB_SEQ_CHECK_EN.
module ahb_lite_sram_slave #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int HSIZE_WIDTH   = 3,
    parameter int BURST_SIZE    = 3,
    parameter int TRANSFER_TYPE = 2,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [ADDRESS_WIDTH-1:0] HADDR,
    input  logic                     HWRITE,
    input  logic [HSIZE_WIDTH-1:0]   HSIZE,
    input  logic [BURST_SIZE-1:0]    HBURST,
    input  logic [TRANSFER_TYPE-1:0] HTRANS,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic                     HREADY,
    output logic                     HRESP
);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     wr_q, wr_d;
    logic [1:0]               size_q, size_d;
    logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];
    logic                     accept, seq_err, err;
    logic [3:0]               be;
    logic                     unused;

    assign HREADY = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign HRESP  = state_q == ST_ERR1 || state_q == ST_ERR2;
    assign HRDATA = (state_q == ST_DATA && !wr_q) ? mem_q[addr_q[IW+1:2]] : '0;
    assign accept = HREADY && HTRANS[1];
    assign err    = HSIZE > HSIZE_WIDTH'(2)
                 || (HSIZE == HSIZE_WIDTH'(1) && HADDR[0])
                 || (HSIZE == HSIZE_WIDTH'(2) && HADDR[1:0] != 2'b00)
                 || (HADDR >> 2) >= ADDRESS_WIDTH'(MEM_DEPTH)
                 || seq_err;
    assign be     = size_q == 2'd0 ? 4'b0001 << addr_q[1:0]
                  : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign unused = ^{HBURST, HTRANS[0], addr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;
        if (state_q == ST_WAIT) begin
            state_d = cnt_q == 4'(WAIT_STATES - 1) ? ST_DATA : ST_WAIT;
            cnt_d   = cnt_q == 4'(WAIT_STATES - 1) ? 4'd0 : cnt_q + 4'd1;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            addr_d  = HADDR;
            wr_d    = HWRITE;
            size_d  = HSIZE[1:0];
            cnt_d   = 4'd0;
            state_d = err ? ST_ERR1 : WAIT_STATES == 0 ? ST_DATA : ST_WAIT;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
        end
    end

    // Memory is deliberately not reset; a write closing on a reset edge is dropped.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == ST_DATA && wr_q)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[addr_q[IW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
    end

`ifdef AHB_SEQ_CHECK_EN
    logic                     seq_v_q, seq_v_d;
    logic [ADDRESS_WIDTH-1:0] seq_a_q, seq_a_d, inc, blk, nxt;
    logic [BURST_SIZE-1:0]    seq_b_q, seq_b_d;
    logic [1:0]               seq_s_q, seq_s_d;

    // blk is the wrap block size in bytes; zero means an incrementing burst.
    always_comb begin
        inc = ADDRESS_WIDTH'(1) << seq_s_q;
        blk = (seq_b_q == BURST_SIZE'(2) ? ADDRESS_WIDTH'(4)
             : seq_b_q == BURST_SIZE'(4) ? ADDRESS_WIDTH'(8)
             : seq_b_q == BURST_SIZE'(6) ? ADDRESS_WIDTH'(16) : ADDRESS_WIDTH'(0)) << seq_s_q;
        nxt = blk == '0 ? seq_a_q + inc
            : (seq_a_q & ~(blk - ADDRESS_WIDTH'(1))) | ((seq_a_q + inc) & (blk - ADDRESS_WIDTH'(1)));
    end

    assign seq_err = HTRANS == TRANSFER_TYPE'(3) && (!seq_v_q || HADDR != nxt);

    always_comb begin
        seq_v_d = seq_v_q;
        seq_a_d = seq_a_q;
        seq_b_d = seq_b_q;
        seq_s_d = seq_s_q;
        if (accept) begin
            seq_v_d = !err;
            seq_a_d = HADDR;
            seq_b_d = HBURST;
            seq_s_d = HSIZE[1:0];
        end else if (HREADY && HTRANS == '0) begin
            seq_v_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            seq_v_q <= 1'b0;
            seq_a_q <= '0;
            seq_b_q <= '0;
            seq_s_q <= '0;
        end else begin
            seq_v_q <= seq_v_d;
            seq_a_q <= seq_a_d;
            seq_b_q <= seq_b_d;
            seq_s_q <= seq_s_d;
        end
    end
`else
    assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: randomized and directed checks of the SRAM slave at 0 and 3 wait states
// against a transaction-level memory and timing model.
module tb_ahb_lite_sram_slave;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] haddr = '0, hwdata = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0, hburst = '0;
    logic [1:0]  htrans = '0;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, rsp0, rsp3;
    int          pass = 0, total = 0, fails = 0;
    logic [31:0] mdl [2][256];

    typedef struct {
        logic [31:0] a;
        bit          w;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [1:0]  tr;
        logic [2:0]  bu;
    } txn_t;
    txn_t q[$];

    always #5 clk = ~clk;

    ahb_lite_sram_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HTRANS(htrans), .HWDATA(hwdata), .HRDATA(rd0), .HREADY(rdy0), .HRESP(rsp0));

    ahb_lite_sram_slave #(.WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HTRANS(htrans), .HWDATA(hwdata), .HRDATA(rd3), .HREADY(rdy3), .HRESP(rsp3));

    function automatic logic [33:0] obs(int s);
        return s != 0 ? {rdy3, rsp3, rd3} : {rdy0, rsp0, rd0};
    endfunction

    task automatic chk(input string tag, input logic [33:0] o, input logic [33:0] e);
        total++;
        assert (o === e) pass++;
        else begin
            fails++;
            $error("FAIL %s observed ready/resp/data=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic bit addr_err(input logic [31:0] a, input logic [2:0] sz);
        return sz > 3'd2 || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) || a >= 32'd1024;
    endfunction

    function automatic logic [31:0] next_a(input logic [31:0] a, input logic [2:0] bu, input logic [1:0] sz);
        int inc = 1 << sz;
        int beats = bu == 3'd2 ? 4 : bu == 3'd4 ? 8 : bu == 3'd6 ? 16 : 0;
        int blk = beats * inc;
        if (beats == 0) return a + inc;
        return (a / blk) * blk + (a % blk + inc) % blk;
    endfunction

    task automatic push(input logic [31:0] a, input bit w, input logic [2:0] sz, input logic [31:0] wd,
                        input logic [1:0] tr = 2'd2, input logic [2:0] bu = 3'd0);
        txn_t t;
        t.a = a; t.w = w; t.sz = sz; t.wd = wd; t.tr = tr; t.bu = bu;
        q.push_back(t);
    endtask

    task automatic drive(input txn_t t);
        haddr = t.a; hwrite = t.w; hsize = t.sz; htrans = t.tr; hburst = t.bu;
    endtask

    task automatic run(input int s, input int ws);
        txn_t        t;
        bit          e, pv;
        int          n, off;
        logic [33:0] ex;
        logic [31:0] pa;
        logic [2:0]  pb;
        logic [1:0]  ps;
        pv = 0; pa = '0; pb = '0; ps = '0;
        drive(q[0]);
        @(posedge clk);
        for (int p = 0; p < q.size(); p++) begin
            t = q[p];
            e = addr_err(t.a, t.sz);
`ifdef AHB_SEQ_CHECK_EN
            if (t.tr == 2'd3 && (!pv || t.a != next_a(pa, pb, ps))) e = 1;
`endif
            n = e ? 2 : ws + 1;
            for (int c = 0; c < n; c++) begin
                #1;
                if (e) ex = c == 0 ? {2'b01, 32'h0} : {2'b11, 32'h0};
                else ex = c < ws ? 34'h0 : {2'b10, t.w ? 32'h0 : mdl[s][t.a[9:2]]};
                chk($sformatf("dut%0d_txn%0d_cyc%0d", s, p, c), obs(s), ex);
                if (p + 1 < q.size()) drive(q[p+1]);
                else htrans = 2'd0;
                hwdata = t.wd;
                @(posedge clk);
            end
            if (!e && t.w) begin
                off = t.a[1:0];
                for (int b = 0; b < (1 << t.sz); b++)
                    mdl[s][t.a[9:2]][8*(off+b) +: 8] = t.wd[8*(off+b) +: 8];
            end
            pv = !e; pa = t.a; pb = t.bu; ps = t.sz[1:0];
        end
        q.delete();
        #1;
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle0_%0d", i), obs(0), {2'b10, 32'h0});
            chk($sformatf("idle3_%0d", i), obs(1), {2'b10, 32'h0});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        repeat (2) @(posedge clk);
        #1;
        chk("reset0", obs(0), {2'b10, 32'h0});
        chk("reset3", obs(1), {2'b10, 32'h0});
        rst = 1'b0;
        idle_chk(3);

        for (int i = 0; i < 256; i++) push(i * 4, 1, 3'd2, $urandom);
        run(0, 0);

        push(32'h10, 1, 3'd2, 32'hDEADBEEF);
        push(32'h10, 0, 3'd2, 32'h0);
        push(32'h20, 1, 3'd2, 32'h0);
        push(32'h22, 1, 3'd0, 32'h00AB0000);
        push(32'h20, 0, 3'd2, 32'h0);
        push(32'h13, 1, 3'd2, 32'h12345678);
        push(32'h10, 0, 3'd2, 32'h0);
        push(32'h400, 1, 3'd2, 32'h55555555);
        push(32'h3FC, 0, 3'd2, 32'h0);
        push(32'h08, 0, 3'd3, 32'h0);
        push(32'h12, 0, 3'd1, 32'h0);
        run(0, 0);
        idle_chk(2);

        push(32'h40, 1, 3'd2, 32'hA0A0A0A0, 2'd2, 3'd3);
        push(32'h44, 1, 3'd2, 32'hB1B1B1B1, 2'd3, 3'd3);
        push(32'h4C, 1, 3'd2, 32'hC2C2C2C2, 2'd3, 3'd3);
        push(32'h4C, 0, 3'd2, 32'h0);
        run(0, 0);
        idle_chk(1);
        push(32'h48, 1, 3'd2, 32'h11111111, 2'd2, 3'd2);
        push(32'h4C, 1, 3'd2, 32'h22222222, 2'd3, 3'd2);
        push(32'h40, 1, 3'd2, 32'h33333333, 2'd3, 3'd2);
        push(32'h44, 1, 3'd2, 32'h44444444, 2'd3, 3'd2);
        push(32'h48, 0, 3'd2, 32'h0);
        push(32'h40, 0, 3'd2, 32'h0);
        run(0, 0);

        for (int i = 0; i < 200; i++) begin
            sz = $urandom_range(0, 7) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
            a = $urandom_range(0, 15) == 0 ? 32'h400 + $urandom_range(0, 63) : $urandom_range(0, 1023);
            if (sz < 3'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            push(a, 1'($urandom_range(0, 1)), sz, $urandom);
        end
        run(0, 0);

        haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
        @(posedge clk);
        #1;
        htrans = 2'd0; hwdata = 32'h11112222; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_write", obs(0), {2'b10, 32'h0});
        push(32'h30, 0, 3'd2, 32'h0);
        run(0, 0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset3_again", obs(1), {2'b10, 32'h0});
        push(32'h0, 1, 3'd2, 32'hCAFEF00D);
        push(32'h0, 0, 3'd2, 32'h0);
        push(32'h13, 0, 3'd2, 32'h0);
        for (int i = 0; i < 4; i++) push(32'h100 + i * 4, 1, 3'd2, $urandom);
        for (int i = 0; i < 12; i++) begin
            sz = 3'($urandom_range(0, 2));
            a = (32'h100 + $urandom_range(0, 15)) & ~((32'd1 << sz) - 32'd1);
            push(a, 1'($urandom_range(0, 1)), sz, $urandom);
        end
        run(1, 3);

        haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2;
        @(posedge clk);
        #1;
        chk("ws3_wait1", obs(1), 34'h0);
        htrans = 2'd0;
        @(posedge clk);
        #1;
        chk("ws3_wait2", obs(1), 34'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ws3_rst_in_wait", obs(1), {2'b10, 32'h0});
        idle_chk(2);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- Synthesizable AHB-Lite slave that is the DUT behind the AHB-Lite interface's DUT modport: consumes HADDR/HWRITE/HSIZE/HBURST/HTRANS/HWDATA; produces HRDATA/HREADY/HRESP.
- Word-organized SRAM model with programmable wait states, byte/halfword/word lanes and two-cycle ERROR response.
- Single slave on the bus, always selected (no HSEL).

Parameters:
- ADDRESS_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width (fixed 32 for this block)
- HSIZE_WIDTH, 3, HSIZE width
- BURST_SIZE, 3, HBURST width
- TRANSFER_TYPE, 2, HTRANS width
- MEM_DEPTH, 256, number of 32-bit words
- WAIT_STATES, 0, HREADY-low cycles inserted per OKAY data phase (0..15)

Ports:
- HCLK  input  1  clock, all logic on rising edge
- HRESET  input  1  synchronous active-high reset
- HADDR  input  ADDRESS_WIDTH  byte address (address phase)
- HWRITE  input  1  1 = write
- HSIZE  input  HSIZE_WIDTH  0 byte, 1 halfword, 2 word
- HBURST  input  BURST_SIZE  burst type (timing-neutral)
- HTRANS  input  TRANSFER_TYPE  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- HWDATA  input  DATA_WIDTH  write data (data phase)
- HRDATA  output  DATA_WIDTH  read data
- HREADY  output  1  transfer complete / slave ready
- HRESP  output  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (HRESET=1 at edge): HREADY=1, HRESP=0, HRDATA=0, FSM=ST_IDLE, wait counter=0. Memory array is not cleared.
- Address-phase acceptance:
  - Address phase is sampled at an edge where HREADY=1 and HTRANS is NONSEQ or SEQ.
  - Latch address, HWRITE, HSIZE.
  - IDLE/BUSY are never latched and get a zero-wait OKAY (HREADY stays 1).
- Error check at acceptance: ERROR when any of
  - HSIZE>2
  - address misaligned (halfword HADDR[0]=1; word HADDR[1:0]!=0)
  - word index HADDR>>2 >= MEM_DEPTH
- FSM states:
  - ST_IDLE: no data phase pending; HREADY=1. A valid accept goes to ST_WAIT if WAIT_STATES>0 and no error, to ST_DATA if WAIT_STATES=0, or to ST_ERR1 on error.
  - ST_WAIT: HREADY=0, HRESP=0. Counter counts WAIT_STATES cycles, then goes to ST_DATA.
  - ST_DATA: HREADY=1, HRESP=0.
    - Read: HRDATA = mem[latched index], full word.
    - Write: HWDATA lanes selected by HSIZE and addr[1:0] are committed at the closing edge; other bytes unchanged.
    - A new accept in this cycle (pipelined) follows the same rules as from ST_IDLE; otherwise go to ST_IDLE.
  - ST_ERR1: HREADY=0, HRESP=1, then ST_ERR2.
  - ST_ERR2: HREADY=1, HRESP=1. No memory access. A new accept is allowed (error-first protocol). Then ST_IDLE or the next state.
- HRDATA = 0 in every cycle except ST_DATA for a read.
- Back-to-back write then read to the same address returns the new data: the write commits before the read's data phase.
- Wrap/incr burst addressing is the master's responsibility; each beat is handled independently.
- HRESET mid-operation: abandons the pending transfer. A write whose ST_DATA edge coincides with HRESET=1 is not committed. Outputs go to reset values at that edge.
- HTRANS changes while HREADY=0 are ignored.

Optional Feature:
- Macro AHB_SEQ_CHECK_EN.
- Defined: the slave tracks the last accepted beat. A SEQ transfer is given a two-cycle ERROR and no memory access when:
  - it follows IDLE/ERROR, or
  - its HADDR differs from the expected address.
- Expected address:
  - INCR types: prev + 2^HSIZE.
  - WRAP4/8/16: address wraps within a (beats × 2^HSIZE)-aligned block.
- BUSY holds the expectation unchanged.
- Undefined: SEQ is treated exactly like NONSEQ; no tracking logic is synthesized.

Test Plan:
- Reset, then idle bus → HREADY=1, HRESP=0, HRDATA=0 every cycle.
- WAIT_STATES=0: NONSEQ write word 0xDEADBEEF @0x10, then NONSEQ read @0x10 in the next address phase → read data phase HRDATA=0xDEADBEEF, HREADY=1, HRESP=0, no stall.
- Word 0x00000000 @0x20, then byte write HSIZE=0 @0x22 data 0x00AB0000, then read @0x20 → HRDATA=0x00AB0000.
- HSIZE=2 @0x13 (misaligned) → HREADY=0/HRESP=1, then HREADY=1/HRESP=1; mem[4] unchanged. Repeat with @0x400 (index 256, out of range).
- WAIT_STATES=3: read @0x0 → exactly 3 cycles HREADY=0, then data with HREADY=1. HRESET=1 during the 2nd wait cycle → next cycle HREADY=1, HRESP=0.
- AHB_SEQ_CHECK_EN: INCR4 word burst 0x40, 0x44, 0x4C → third beat gets two-cycle ERROR. WRAP4 0x48, 0x4C, 0x40, 0x44 → all OKAY.
